// File: rtl/rob_tagged.sv
// Tagged reorder buffer: allocates entries in program order, accepts results from
// several writeback ports by tag, retires one entry per cycle and handles rollback.
module rob_tagged #(
    parameter int DEPTH  = 64,
    parameter int NUM_WB = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [4:0]               alloc_dest,
    input  logic                     alloc_reg_write,
    input  logic                     alloc_mem_write,
    input  logic [31:0]              alloc_pc,
    input  logic                     alloc_exc,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_value,
    input  logic [NUM_WB-1:0]        wb_exc,
    input  logic [NUM_WB*2-1:0]      wb_cause,
    input  logic                     br_flush,
    input  logic [TAG_W-1:0]         br_tag,
    output logic                     commit_valid,
    output logic [TAG_W-1:0]         commit_tag,
    output logic [4:0]               commit_dest,
    output logic [DATA_W-1:0]        commit_value,
    output logic                     commit_reg_write,
    output logic                     commit_mem_write,
    output logic                     exception_sig,
    output logic [1:0]               exception_cause,
    output logic [31:0]              epc,
    output logic [TAG_W:0]           count
);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_exc;
    logic [DEPTH-1:0]  r_reg_write;
    logic [DEPTH-1:0]  r_mem_write;
    logic [1:0]        r_cause [DEPTH];
    logic [4:0]        r_dest  [DEPTH];
    logic [31:0]       r_pc    [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              r_commit_valid;
    logic [TAG_W-1:0]  r_commit_tag;
    logic [4:0]        r_commit_dest;
    logic [DATA_W-1:0] r_commit_value;
    logic              r_commit_reg_write;
    logic              r_commit_mem_write;
    logic              r_exception_sig;
    logic [1:0]        r_exception_cause;
    logic [31:0]       r_epc;

    logic              w_full;
    logic              w_empty;
    logic              w_head_done;
    logic              w_commit;
    logic              w_exc_pending;
    logic              w_alloc;
    logic              w_flush;
    logic [TAG_W-1:0]  w_br_age;
    logic [DEPTH-1:0]  w_kill;
    logic [TAG_W:0]    w_count_nxt;

    // Age relative to the head; modular subtraction keeps ordering valid across the wrap.
    function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] idx,
                                                input logic [TAG_W-1:0] head);
        return idx - head;
    endfunction

    assign w_full        = (r_count == (TAG_W+1)'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_head_done   = r_valid[r_head] && r_ready[r_head];
    assign w_commit      = w_head_done && !r_exc[r_head];
    assign w_exc_pending = w_head_done && r_exc[r_head];
    assign alloc_ready   = !w_full && !br_flush && !w_exc_pending;
    assign alloc_tag     = r_tail;
    assign w_alloc       = alloc_valid && alloc_ready;
    assign w_flush       = br_flush && !w_empty && !w_exc_pending;
    assign w_br_age      = age_of(br_tag, r_head);

    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = w_flush && (age_of(TAG_W'(i), r_head) > w_br_age);
        end
    end

    always_comb begin
        if (w_flush) begin
            w_count_nxt = {1'b0, w_br_age} + (TAG_W+1)'(1) - (TAG_W+1)'(w_commit);
        end else begin
            w_count_nxt = r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
        end
    end

    // Entry status flags; later statements override earlier ones (higher port, then clears).
    always_ff @(posedge clk) begin
        if (rst || w_exc_pending) begin
            r_valid <= '0;
            r_ready <= '0;
            r_exc   <= '0;
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && r_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
                    r_ready[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    if (wb_exc[p]) begin
                        r_exc[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    end
                end
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= alloc_exc;
                r_exc[r_tail]   <= alloc_exc;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                    r_ready[i] <= 1'b0;
                    r_exc[i]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && r_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
                r_value[wb_tag[p*TAG_W +: TAG_W]] <= wb_value[p*DATA_W +: DATA_W];
                if (wb_exc[p]) begin
                    r_cause[wb_tag[p*TAG_W +: TAG_W]] <= wb_cause[p*2 +: 2];
                end
            end
        end
        if (w_alloc) begin
            r_dest[r_tail]      <= alloc_dest;
            r_pc[r_tail]        <= alloc_pc;
            r_reg_write[r_tail] <= alloc_reg_write;
            r_mem_write[r_tail] <= alloc_mem_write;
            r_cause[r_tail]     <= 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_exc_pending) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_commit) begin
                r_head <= r_head + TAG_W'(1);
            end
            if (w_flush) begin
                r_tail <= br_tag + TAG_W'(1);
            end else if (w_alloc) begin
                r_tail <= r_tail + TAG_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_valid     <= 1'b0;
            r_commit_tag       <= '0;
            r_commit_dest      <= '0;
            r_commit_value     <= '0;
            r_commit_reg_write <= 1'b0;
            r_commit_mem_write <= 1'b0;
            r_exception_sig    <= 1'b0;
            r_exception_cause  <= '0;
            r_epc              <= '0;
        end else begin
            r_commit_valid     <= w_commit;
            r_commit_reg_write <= w_commit && r_reg_write[r_head];
            r_commit_mem_write <= w_commit && r_mem_write[r_head];
            r_exception_sig    <= w_exc_pending;
            if (w_commit) begin
                r_commit_tag   <= r_head;
                r_commit_dest  <= r_dest[r_head];
                r_commit_value <= r_value[r_head];
            end
            if (w_exc_pending) begin
                r_exception_cause <= r_cause[r_head];
                r_epc             <= r_pc[r_head];
            end
        end
    end

    assign commit_valid     = r_commit_valid;
    assign commit_tag       = r_commit_tag;
    assign commit_dest      = r_commit_dest;
    assign commit_value     = r_commit_value;
    assign commit_reg_write = r_commit_reg_write;
    assign commit_mem_write = r_commit_mem_write;
    assign exception_sig    = r_exception_sig;
    assign exception_cause  = r_exception_cause;
    assign epc              = r_epc;
    assign count            = r_count;

endmodule

// File: tb/tb_rob_tagged.sv
// Scoreboard bench for rob_tagged: expected commits are queued at stimulus time
// and compared in order against commits captured from the DUT.
module tb_rob_tagged;

    localparam int TW = 6;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [4:0]    dest;
        logic [31:0]   value;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alloc_valid = 1'b0;
    logic            alloc_ready;
    logic [TW-1:0]   alloc_tag;
    logic [4:0]      alloc_dest = '0;
    logic            alloc_reg_write = 1'b0;
    logic            alloc_mem_write = 1'b0;
    logic [31:0]     alloc_pc = '0;
    logic            alloc_exc = 1'b0;
    logic [3:0]      wb_valid = '0;
    logic [4*TW-1:0] wb_tag = '0;
    logic [127:0]    wb_value = '0;
    logic [3:0]      wb_exc = '0;
    logic [7:0]      wb_cause = '0;
    logic            br_flush = 1'b0;
    logic [TW-1:0]   br_tag = '0;
    logic            commit_valid;
    logic [TW-1:0]   commit_tag;
    logic [4:0]      commit_dest;
    logic [31:0]     commit_value;
    logic            commit_reg_write;
    logic            commit_mem_write;
    logic            exception_sig;
    logic [1:0]      exception_cause;
    logic [31:0]     epc;
    logic [TW:0]     count;

    int n_cmp = 0;
    int n_err = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    rob_tagged #(.DEPTH(64), .NUM_WB(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_dest(alloc_dest), .alloc_reg_write(alloc_reg_write),
        .alloc_mem_write(alloc_mem_write), .alloc_pc(alloc_pc), .alloc_exc(alloc_exc),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_exc(wb_exc), .wb_cause(wb_cause),
        .br_flush(br_flush), .br_tag(br_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_reg_write(commit_reg_write),
        .commit_mem_write(commit_mem_write), .exception_sig(exception_sig),
        .exception_cause(exception_cause), .epc(epc), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (commit_valid === 1'b1) obs_q.push_back({commit_tag, commit_dest, commit_value});
    end

    function automatic rec_t mk(input int t, input logic [31:0] v);
        rec_t r;
        r.tag = TW'(t);
        r.dest = 5'(t);
        r.value = v;
        return r;
    endfunction

    task automatic set_wb(input int p, input int t, input logic [31:0] v,
                          input logic e, input logic [1:0] c);
        wb_valid[p] = 1'b1;
        wb_tag[p*TW +: TW] = TW'(t);
        wb_value[p*32 +: 32] = v;
        wb_exc[p] = e;
        wb_cause[p*2 +: 2] = c;
    endtask

    task automatic clear_wb();
        wb_valid = '0;
        wb_exc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_valid = 1'b0; alloc_exc = 1'b0; br_flush = 1'b0; clear_wb();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_dest = alloc_tag[4:0];
            alloc_reg_write = 1'b1;
            alloc_pc = 32'h100 + {24'd0, alloc_tag, 2'b00};
            @(negedge clk);
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got %b required 0", commit_valid); end
        n_cmp++; if (exception_sig !== 1'b0) begin n_err++; $display("FAIL reset_exception_sig got %b required 0", exception_sig); end
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL reset_count got %0d required 0", count); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready got %b required 1", alloc_ready); end
        n_cmp++; if (alloc_tag !== 6'd0) begin n_err++; $display("FAIL reset_alloc_tag got %0d required 0", alloc_tag); end
        n_cmp++; if (epc !== 32'd0 || exception_cause !== 2'd0) begin n_err++; $display("FAIL reset_epc_cause got %h/%b required 0/00", epc, exception_cause); end
    endtask

    task automatic test_inorder();
        rec_t e, o;
        do_reset();
        alloc_n(3);
        exp_q.push_back(mk(0, 32'h00));
        exp_q.push_back(mk(1, 32'h11));
        exp_q.push_back(mk(2, 32'h22));
        set_wb(0, 2, 32'h22, 1'b0, 2'b00); @(negedge clk); clear_wb();
        set_wb(1, 0, 32'h00, 1'b0, 2'b00); @(negedge clk); clear_wb();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL inorder_no_bypass got %b required 0", commit_valid); end
        set_wb(2, 1, 32'h11, 1'b0, 2'b00); @(negedge clk); clear_wb();
        n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0) begin n_err++; $display("FAIL inorder_latency got valid=%b tag=%0d required valid=1 tag=0", commit_valid, commit_tag); end
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL inorder_commit missing, required tag=%0d", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL inorder_commit got tag=%0d dest=%0d val=%h required tag=%0d dest=%0d val=%h", o.tag, o.dest, o.value, e.tag, e.dest, e.value); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL inorder_extra got %0d extra commits required 0", obs_q.size()); end
        n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL inorder_count got %0d required 0", count); end
    endtask

    task automatic test_full_wrap();
        rec_t e, o;
        do_reset();
        alloc_n(64);
        n_cmp++; if (alloc_ready !== 1'b0 || count !== 7'd64) begin n_err++; $display("FAIL full_state got ready=%b count=%0d required ready=0 count=64", alloc_ready, count); end
        alloc_valid = 1'b1;
        set_wb(2, 0, 32'h5A, 1'b0, 2'b00);
        exp_q.push_back(mk(0, 32'h5A));
        @(negedge clk); clear_wb();
        n_cmp++; if (alloc_ready !== 1'b0 || count !== 7'd64) begin n_err++; $display("FAIL full_commit_cycle got ready=%b count=%0d required ready=0 count=64", alloc_ready, count); end
        @(negedge clk);
        n_cmp++; if (count !== 7'd63 || alloc_ready !== 1'b1 || alloc_tag !== 6'd0) begin n_err++; $display("FAIL full_freed got count=%0d ready=%b tag=%0d required 63/1/0", count, alloc_ready, alloc_tag); end
        alloc_n(1);
        n_cmp++; if (count !== 7'd64 || alloc_tag !== 6'd1) begin n_err++; $display("FAIL wrap_alloc got count=%0d tag=%0d required 64/1", count, alloc_tag); end
        br_flush = 1'b1; br_tag = 6'd0;
        @(negedge clk); br_flush = 1'b0;
        n_cmp++; if (count !== 7'd64 || alloc_tag !== 6'd1) begin n_err++; $display("FAIL flush_noop got count=%0d tag=%0d required 64/1", count, alloc_tag); end
        br_flush = 1'b1; br_tag = 6'd3;
        @(negedge clk); br_flush = 1'b0;
        n_cmp++; if (count !== 7'd3 || alloc_tag !== 6'd4) begin n_err++; $display("FAIL flush_wrap got count=%0d tag=%0d required 3/4", count, alloc_tag); end
        for (int t = 1; t <= 3; t++) begin
            set_wb(t - 1, t, 32'h100 + t, 1'b0, 2'b00);
            exp_q.push_back(mk(t, 32'h100 + t));
        end
        set_wb(3, 0, 32'hDEAD, 1'b0, 2'b00);
        @(negedge clk); clear_wb();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL wrap_commit missing, required tag=%0d", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL wrap_commit got tag=%0d dest=%0d val=%h required tag=%0d dest=%0d val=%h", o.tag, o.dest, o.value, e.tag, e.dest, e.value); end
            end
        end
        n_cmp++; if (obs_q.size() != 0 || count !== 7'd0) begin n_err++; $display("FAIL wrap_end got extra=%0d count=%0d required 0/0", obs_q.size(), count); end
    endtask

    task automatic test_flush();
        rec_t e, o;
        do_reset();
        alloc_n(6);
        br_flush = 1'b1; br_tag = 6'd2; alloc_valid = 1'b1;
        set_wb(0, 4, 32'h44, 1'b0, 2'b00);
        #1;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_alloc_ready got %b required 0", alloc_ready); end
        @(negedge clk);
        br_flush = 1'b0; alloc_valid = 1'b0; clear_wb();
        n_cmp++; if (count !== 7'd3 || alloc_tag !== 6'd3) begin n_err++; $display("FAIL flush_ptrs got count=%0d tag=%0d required 3/3", count, alloc_tag); end
        for (int t = 0; t < 3; t++) begin
            set_wb(t, t, 32'h30 + t, 1'b0, 2'b00);
            exp_q.push_back(mk(t, 32'h30 + t));
        end
        set_wb(3, 4, 32'h34, 1'b0, 2'b00);
        @(negedge clk); clear_wb();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL flush_commit missing, required tag=%0d", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL flush_commit got tag=%0d dest=%0d val=%h required tag=%0d dest=%0d val=%h", o.tag, o.dest, o.value, e.tag, e.dest, e.value); end
            end
        end
        n_cmp++; if (obs_q.size() != 0 || count !== 7'd0) begin n_err++; $display("FAIL flush_end got extra=%0d count=%0d required 0/0", obs_q.size(), count); end
    endtask

    task automatic test_exception();
        rec_t o;
        bit found = 1'b0;
        do_reset();
        alloc_n(3);
        set_wb(0, 0, 32'h10, 1'b0, 2'b00);
        set_wb(1, 1, 32'h77, 1'b1, 2'b01);
        @(negedge clk); clear_wb();
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (exception_sig === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL exc_pulse got none within 10 cycles required 1"); end
        else begin
            if (exception_cause !== 2'b01 || epc !== 32'h104 || count !== 7'd0 || alloc_tag !== 6'd0 || commit_valid !== 1'b0) begin
                n_err++; $display("FAIL exc_state got cause=%b epc=%h count=%0d tag=%0d cv=%b required 01/104/0/0/0", exception_cause, epc, count, alloc_tag, commit_valid);
            end
        end
        @(negedge clk);
        n_cmp++; if (exception_sig !== 1'b0 || exception_cause !== 2'b01) begin n_err++; $display("FAIL exc_hold got sig=%b cause=%b required 0/01", exception_sig, exception_cause); end
        n_cmp++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL exc_commits got %0d commits required 1", obs_q.size()); end
        else begin
            o = obs_q.pop_front();
            if (o !== mk(0, 32'h10)) begin n_err++; $display("FAIL exc_commit got tag=%0d val=%h required tag=0 val=10", o.tag, o.value); end
        end
    endtask

    task automatic test_alloc_exc();
        exp_q.delete(); obs_q.delete();
        alloc_valid = 1'b1; alloc_exc = 1'b1; alloc_pc = 32'h200; alloc_dest = 5'd7;
        @(negedge clk);
        alloc_valid = 1'b0; alloc_exc = 1'b0;
        n_cmp++; if (exception_sig !== 1'b0 || alloc_ready !== 1'b0 || count !== 7'd1) begin n_err++; $display("FAIL allocexc_pending got sig=%b ready=%b count=%0d required 0/0/1", exception_sig, alloc_ready, count); end
        @(negedge clk);
        n_cmp++; if (exception_sig !== 1'b1 || exception_cause !== 2'b00 || epc !== 32'h200 || count !== 7'd0) begin n_err++; $display("FAIL allocexc_fire got sig=%b cause=%b epc=%h count=%0d required 1/00/200/0", exception_sig, exception_cause, epc, count); end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL allocexc_commits got %0d required 0", obs_q.size()); end
    endtask

    task automatic test_same_tag();
        rec_t e, o;
        do_reset();
        alloc_n(6);
        for (int t = 0; t < 4; t++) begin
            set_wb(t, t, 32'h50 + t, 1'b0, 2'b00);
            exp_q.push_back(mk(t, 32'h50 + t));
        end
        @(negedge clk); clear_wb();
        set_wb(0, 5, 32'hAA, 1'b0, 2'b00);
        set_wb(3, 5, 32'hBB, 1'b0, 2'b00);
        set_wb(1, 4, 32'h54, 1'b0, 2'b00);
        set_wb(2, 9, 32'h99, 1'b0, 2'b00);
        exp_q.push_back(mk(4, 32'h54));
        exp_q.push_back(mk(5, 32'hBB));
        @(negedge clk); clear_wb();
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL sametag_commit missing, required tag=%0d", e.tag); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL sametag_commit got tag=%0d dest=%0d val=%h required tag=%0d dest=%0d val=%h", o.tag, o.dest, o.value, e.tag, e.dest, e.value); end
            end
        end
        n_cmp++; if (obs_q.size() != 0 || count !== 7'd0 || alloc_tag !== 6'd6) begin n_err++; $display("FAIL sametag_end got extra=%0d count=%0d tag=%0d required 0/0/6", obs_q.size(), count, alloc_tag); end
    endtask

    task automatic test_rst_mid();
        exp_q.delete(); obs_q.delete();
        alloc_n(10);
        set_wb(0, 0, 32'hC0, 1'b0, 2'b00); @(negedge clk); clear_wb();
        @(negedge clk);
        n_cmp++; if (commit_valid !== 1'b1 || commit_value !== 32'hC0) begin n_err++; $display("FAIL rstmid_precommit got cv=%b val=%h required 1/C0", commit_valid, commit_value); end
        set_wb(0, 1, 32'hC1, 1'b0, 2'b00); @(negedge clk); clear_wb();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (commit_valid !== 1'b0 || commit_value !== 32'd0 || commit_tag !== 6'd0 || commit_dest !== 5'd0 || commit_reg_write !== 1'b0 || commit_mem_write !== 1'b0) begin
            n_err++; $display("FAIL rstmid_commit_out got cv=%b val=%h tag=%0d dest=%0d rw=%b mw=%b required all 0", commit_valid, commit_value, commit_tag, commit_dest, commit_reg_write, commit_mem_write);
        end
        n_cmp++; if (exception_sig !== 1'b0 || exception_cause !== 2'd0 || epc !== 32'd0) begin n_err++; $display("FAIL rstmid_exc_out got sig=%b cause=%b epc=%h required 0/00/0", exception_sig, exception_cause, epc); end
        n_cmp++; if (count !== 7'd0 || alloc_tag !== 6'd0 || alloc_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ptrs got count=%0d tag=%0d ready=%b required 0/0/1", count, alloc_tag, alloc_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after got cv=%b required 0", commit_valid); end
    endtask

    initial begin
        test_reset();
        test_inorder();
        test_full_wrap();
        test_flush();
        test_exception();
        test_alloc_exc();
        test_rst_mid();
        test_same_tag();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
